// File: rtl/ps2_kbd_pkg.sv
// Shared scancodes, command codes, writer states and the scancode-to-command map
// for the PS/2 keyboard command writer.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [4:0] CMD_LEFT  = 5'h03;
  localparam logic [4:0] CMD_RIGHT = 5'h05;
  localparam logic [4:0] CMD_UP    = 5'h04;
  localparam logic [4:0] CMD_DOWN  = 5'h16;
  localparam logic [4:0] CMD_ENTER = 5'h1E;
  localparam logic [4:0] CMD_SPACE = 5'h1F;
  localparam logic [4:0] CMD_ESC   = 5'h01;

  localparam int KEY_COUNT = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SET,
    ST_HOLD,
    ST_CLEAR
  } wr_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] cmd;
  } cmd_map_t;

  function automatic cmd_map_t map_scancode(input logic ext, input logic [7:0] code);
    cmd_map_t m;
    m = '{valid: 1'b0, cmd: 5'h00};
    case ({ext, code})
      {1'b1, SC_LEFT}:  m = '{valid: 1'b1, cmd: CMD_LEFT};
      {1'b1, SC_RIGHT}: m = '{valid: 1'b1, cmd: CMD_RIGHT};
      {1'b1, SC_UP}:    m = '{valid: 1'b1, cmd: CMD_UP};
      {1'b1, SC_DOWN}:  m = '{valid: 1'b1, cmd: CMD_DOWN};
      {1'b0, SC_ENTER}: m = '{valid: 1'b1, cmd: CMD_ENTER};
      {1'b0, SC_SPACE}: m = '{valid: 1'b1, cmd: CMD_SPACE};
      {1'b0, SC_ESC}:   m = '{valid: 1'b1, cmd: CMD_ESC};
      default:          m = '{valid: 1'b0, cmd: 5'h00};
    endcase
    return m;
  endfunction

  // Slot of each mapped key in the held-key bitmap; only meaningful for mapped keys.
  function automatic logic [2:0] key_index(input logic ext, input logic [7:0] code);
    logic [2:0] idx;
    case ({ext, code})
      {1'b1, SC_LEFT}:  idx = 3'd0;
      {1'b1, SC_RIGHT}: idx = 3'd1;
      {1'b1, SC_UP}:    idx = 3'd2;
      {1'b1, SC_DOWN}:  idx = 3'd3;
      {1'b0, SC_ENTER}: idx = 3'd4;
      {1'b0, SC_SPACE}: idx = 3'd5;
      default:          idx = 3'd6;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, 11-bit shift,
// start/stop/odd-parity check and inter-edge timeout.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  // [0],[1] synchronize; [2] is the previous synced value for edge detection.
  logic [2:0]      clk_pipe_q, clk_pipe_d;
  logic [1:0]      data_pipe_q, data_pipe_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  logic fall;
  logic data_s;

  assign fall   = clk_pipe_q[2] & ~clk_pipe_q[1];
  assign data_s = data_pipe_q[1];

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    clk_pipe_d   = {clk_pipe_q[1:0], ps2_clk};
    data_pipe_d  = {data_pipe_q[0], ps2_data};
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        // shift_q[0]=start, [8:1]=data, [9]=parity; data_s is the stop bit.
        if (!shift_q[0] && data_s && (^shift_q[9:1])) begin
          rx_byte_d    = shift_q[8:1];
          byte_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {data_s, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d   = '0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // Synchronizers reset to the idle-high line level so release creates no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_pipe_q   <= 3'b111;
      data_pipe_q  <= 2'b11;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_pipe_q   <= clk_pipe_d;
      data_pipe_q  <= data_pipe_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_keyboard_cmd_writer.sv
// Decodes PS/2 scancodes into game commands and writes {cmd, pending} into the
// instruction memory patch port. Define KBD_TYPEMATIC_FILTER_EN to drop typematic repeats.
module ps2_keyboard_cmd_writer
  import ps2_kbd_pkg::*;
#(
  parameter int HOLD_CYCLES    = 50000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [5:0] keyboard,
  output logic       WriteEnable,
  output logic       frame_err
);

  localparam int HC_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  logic [7:0] rx_byte;
  logic       byte_valid;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // ---------------- scancode decoder ----------------
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [4:0] cmd_q, cmd_d;
  cmd_map_t   hit;
`ifdef KBD_TYPEMATIC_FILTER_EN
  logic [KEY_COUNT-1:0] held_q, held_d;
  logic [2:0]           hit_idx;
`endif

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    hit         = map_scancode(ext_q, rx_byte);
`ifdef KBD_TYPEMATIC_FILTER_EN
    held_d      = held_q;
    hit_idx     = key_index(ext_q, rx_byte);
`endif
    if (byte_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
        if (hit.valid) begin
          if (brk_q) begin
            held_d[hit_idx] = 1'b0;
          end else if (!held_q[hit_idx]) begin
            held_d[hit_idx] = 1'b1;
            cmd_valid_d     = 1'b1;
            cmd_d           = hit.cmd;
          end
        end
`else
        if (hit.valid && !brk_q) begin
          cmd_valid_d = 1'b1;
          cmd_d       = hit.cmd;
        end
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
`ifdef KBD_TYPEMATIC_FILTER_EN
      held_q      <= '0;
`endif
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
`ifdef KBD_TYPEMATIC_FILTER_EN
      held_q      <= held_d;
`endif
    end
  end

  // ---------------- writer FSM ----------------
  wr_state_e state_q, state_d;
  logic [4:0]      cur_cmd_q, cur_cmd_d;
  logic [4:0]      pend_cmd_q, pend_cmd_d;
  logic            pend_valid_q, pend_valid_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [5:0]      kbd_q, kbd_d;
  logic            hold_done;

  // HOLD lasts HOLD_CYCLES-1 cycles, so SET and CLEAR are HOLD_CYCLES apart.
  assign hold_done = (hold_cnt_q == HC_W'(HOLD_CYCLES - 2));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pend_valid_q || cmd_valid_q) state_d = ST_SET;
      ST_SET:   state_d = ST_HOLD;
      ST_HOLD:  if (hold_done) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    WriteEnable = (state_q == ST_SET) || (state_q == ST_CLEAR);
    keyboard    = kbd_q;
  end

  // Datapath: pending buffer, latched command, hold counter and keyboard word.
  always_comb begin
    cur_cmd_d    = cur_cmd_q;
    pend_cmd_d   = pend_cmd_q;
    pend_valid_d = pend_valid_q;
    hold_cnt_d   = hold_cnt_q;
    kbd_d        = kbd_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          // Pending is served first; a same-cycle arrival becomes the new pending.
          cur_cmd_d    = pend_cmd_q;
          pend_valid_d = cmd_valid_q;
          if (cmd_valid_q) pend_cmd_d = cmd_q;
          kbd_d = {pend_cmd_q, 1'b1};
        end else if (cmd_valid_q) begin
          cur_cmd_d = cmd_q;
          kbd_d     = {cmd_q, 1'b1};
        end
      end
      ST_SET: begin
        hold_cnt_d = '0;
      end
      ST_HOLD: begin
        if (hold_done) kbd_d = {cur_cmd_q, 1'b0};
        else           hold_cnt_d = hold_cnt_q + HC_W'(1);
      end
      default: ;
    endcase
    if (state_q != ST_IDLE && cmd_valid_q) begin
      pend_cmd_d   = cmd_q;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_cmd_q    <= '0;
      pend_cmd_q   <= '0;
      pend_valid_q <= 1'b0;
      hold_cnt_q   <= '0;
      kbd_q        <= '0;
    end else begin
      cur_cmd_q    <= cur_cmd_d;
      pend_cmd_q   <= pend_cmd_d;
      pend_valid_q <= pend_valid_d;
      hold_cnt_q   <= hold_cnt_d;
      kbd_q        <= kbd_d;
    end
  end

endmodule
